// File: rtl/cruise_alu.sv
// cruise_alu: arithmetic/compare unit of the cruise-control datapath.
// Each clock it registers a new speed value chosen by `mode` (HOLD, INC,
// DEC, LOAD) and one-hot compare flags of current vs. set-point speed.
// Every output comes straight from a flop, with one cycle of latency and no handshake.
// There is no handshake: an operation is accepted on every rising clk edge.
// Optional build macro CRUISE_ALU_SAT_EN: when defined, INC saturates at
// MAX_SPEED and DEC floors at MIN_SPEED. When undefined, both wrap
// modulo 2^WIDTH and the speed bounds are not used.
module cruise_alu #(
  parameter int WIDTH     = 8,
  parameter int STEP      = 1,
  parameter int MAX_SPEED = 200,
  parameter int MIN_SPEED = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] default_speed,
  input  logic [WIDTH-1:0] current_speed,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] result,
  output logic             G,
  output logic             Eq,
  output logic             L
);

  // Operation encodings for the mode input.
  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_INC  = 2'd1;
  localparam logic [1:0] MODE_DEC  = 2'd2;
  localparam logic [1:0] MODE_LOAD = 2'd3;

  // STEP at operand width, used for the in-range increment and decrement.
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Parameter sanity: the bounds must fit in the operand width.
  if (MAX_SPEED > (2 ** WIDTH) - 1) begin : g_bad_max
    $error("cruise_alu: MAX_SPEED does not fit in WIDTH bits");
  end
  if (MIN_SPEED < 0 || MIN_SPEED > MAX_SPEED) begin : g_bad_min
    $error("cruise_alu: MIN_SPEED must lie in 0..MAX_SPEED");
  end
  if (STEP < 0 || STEP > (2 ** WIDTH) - 1) begin : g_bad_step
    $error("cruise_alu: STEP must lie in 0..2^WIDTH-1");
  end

  logic [WIDTH-1:0] inc_value;
  logic [WIDTH-1:0] dec_value;
  logic [WIDTH-1:0] next_result;
  logic             next_g;
  logic             next_eq;
  logic             next_l;

`ifdef CRUISE_ALU_SAT_EN
  // The bound checks run at WIDTH+1 bits, so the increment carry is visible.
  localparam logic [WIDTH:0]   STEP_X      = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   MAX_X       = (WIDTH+1)'(MAX_SPEED);
  localparam logic [WIDTH:0]   DEC_FLOOR_X = (WIDTH+1)'(MIN_SPEED + STEP);
  localparam logic [WIDTH-1:0] MAX_W       = WIDTH'(MAX_SPEED);
  localparam logic [WIDTH-1:0] MIN_W       = WIDTH'(MIN_SPEED);

  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] cur_x;

  // Saturating INC/DEC. An input already above MAX_SPEED clamps to MAX_SPEED.
  always_comb begin
    cur_x   = {1'b0, current_speed};
    inc_sum = cur_x + STEP_X;
    if (inc_sum > MAX_X) begin
      inc_value = MAX_W;
    end else begin
      inc_value = inc_sum[WIDTH-1:0];
    end
    // Subtraction cannot underflow on this branch because of the floor compare.
    if (cur_x >= DEC_FLOOR_X) begin
      dec_value = current_speed - STEP_W;
    end else begin
      dec_value = MIN_W;
    end
  end
`else
  // Wrapping INC/DEC modulo 2^WIDTH. The speed bounds play no part.
  always_comb begin
    inc_value = current_speed + STEP_W;
    dec_value = current_speed - STEP_W;
  end
`endif

  // Mode decode and speed comparison for the next registered values.
  always_comb begin
    next_result = current_speed;
    unique case (mode)
      MODE_HOLD: next_result = current_speed;
      MODE_INC:  next_result = inc_value;
      MODE_DEC:  next_result = dec_value;
      MODE_LOAD: next_result = default_speed;
      default:   next_result = current_speed;
    endcase
    next_g  = (current_speed >  default_speed);
    next_eq = (current_speed == default_speed);
    next_l  = (current_speed <  default_speed);
  end

  // Output registers. Reset clears them immediately, without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      G      <= 1'b0;
      Eq     <= 1'b0;
      L      <= 1'b0;
    end else begin
      result <= next_result;
      G      <= next_g;
      Eq     <= next_eq;
      L      <= next_l;
    end
  end

endmodule

// File: tb/tb_cruise_alu.sv
// tb_cruise_alu: randomized and directed bench for cruise_alu.
// Each expected output word is {result, G, Eq, L}.
module tb_cruise_alu;

  localparam int WIDTH     = 8;
  localparam int STEP      = 1;
  localparam int MAX_SPEED = 200;
  localparam int MIN_SPEED = 0;
  localparam int W         = WIDTH + 3;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] default_speed;
  logic [WIDTH-1:0] current_speed;
  logic [1:0]       mode;
  logic [WIDTH-1:0] result;
  logic             G;
  logic             Eq;
  logic             L;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  cruise_alu #(
    .WIDTH(WIDTH), .STEP(STEP), .MAX_SPEED(MAX_SPEED), .MIN_SPEED(MIN_SPEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .default_speed(default_speed),
    .current_speed(current_speed), .mode(mode), .result(result),
    .G(G), .Eq(Eq), .L(L)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: any hang becomes a reported failure.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=hung required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Behavioural speed rules written with plain integer arithmetic.
  function automatic logic [W-1:0] model(input int def, input int cur, input int md);
    int r;
    int modulus;
    logic [WIDTH-1:0] rv;
    modulus = 1 << WIDTH;
    case (md)
      0: r = cur;
      1: begin
`ifdef CRUISE_ALU_SAT_EN
        r = (cur + STEP > MAX_SPEED) ? MAX_SPEED : cur + STEP;
`else
        r = (cur + STEP) % modulus;
`endif
      end
      2: begin
`ifdef CRUISE_ALU_SAT_EN
        r = (cur >= MIN_SPEED + STEP) ? cur - STEP : MIN_SPEED;
`else
        r = (cur - STEP + modulus) % modulus;
`endif
      end
      default: r = def;
    endcase
    rv = WIDTH'(r);
    return {rv, (cur > def), (cur == def), (cur < def)};
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one operation on the falling edge and queue its expected response.
  task automatic drive(input int def, input int cur, input int md);
    @(negedge clk);
    default_speed = WIDTH'(def);
    current_speed = WIDTH'(cur);
    mode          = 2'(md);
    exp_q.push_back(model(def, cur, md));
  endtask

  // Compare the live outputs against zero during reset.
  task automatic check_zero(input string name);
    checks++;
    if ({result, G, Eq, L} !== '0) begin
      errors++;
      $display("FAIL %s: actual result=%0d G=%0b Eq=%0b L=%0b required all zero",
               name, result, G, Eq, L);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // The DUT presents a fresh result after every rising edge, so it is compared just after the edge.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if ({result, G, Eq, L} !== exp) begin
          errors++;
          $display("FAIL result_flags: in def=%0d cur=%0d actual result=%0d G=%0b Eq=%0b L=%0b required result=%0d G=%0b Eq=%0b L=%0b",
                   default_speed, current_speed, result, G, Eq, L,
                   exp[W-1:3], exp[2], exp[1], exp[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int def;
    int cur;
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    default_speed = 8'd50;
    current_speed = 8'd70;
    mode          = 2'd1;
    #1;
    check_zero("reset_no_clock");
    @(posedge clk);
    #1;
    check_zero("reset_held_over_edge");

    // Reset is released on a falling edge with INC 70 queued; the expected result is 71 with G set.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(50, 70, 1));

    // Directed vectors from the test plan plus boundaries.
    drive(50, 50, 2);
    drive(50, 50, 3);
    drive(90, 30, 0);
    drive(10, 200, 1);
    drive(10, 0, 2);
    drive(10, 255, 1);
    drive(10, 199, 1);
    drive(10, 201, 1);
    drive(10, 1, 2);
    drive(255, 255, 0);
    drive(0, 0, 3);

    // Random operands with modes cycling 0..3, plus an asynchronous reset partway through.
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0: cur = $urandom_range(0, 3);
        1: cur = $urandom_range(196, 255);
        default: cur = $urandom_range(0, 255);
      endcase
      def = ($urandom_range(0, 3) == 0) ? cur : $urandom_range(0, 255);
      drive(def, cur, i % 4);
      if (i == 100) begin
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_zero("async_reset_mid_sequence");
        @(posedge clk);
        #1;
        check_zero("reset_mid_held_over_edge");
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    // Drain: allow the last response to be compared, then require an empty queue.
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
